// File: rtl/aes_ctrl_pkg.sv
// Shared types and sizes for the AES input path: byte, beat and block views,
// plus the issue-FSM state encoding.
package aes_ctrl_pkg;

  localparam int NB     = 16;
  localparam int NROWS  = 4;
  localparam int NBEATS = NB / NROWS;
  localparam int IW     = $clog2(NBEATS);

  typedef logic [7:0]            byte_t;
  typedef byte_t [NROWS-1:0]     beat_t;
  typedef byte_t [NB-1:0]        block_t;

  typedef enum logic [1:0] {
    O_IDLE,
    O_ISSUE,
    O_GUARD
  } iss_state_t;

endpackage

// File: rtl/aes_blk_slots.sv
// Block buffer: NSLOT 16-byte slots, written one 4-byte lane per beat and
// zero-filled above the closing beat on commit. Read is addressed by slot.
module aes_blk_slots
  import aes_ctrl_pkg::*;
#(
  parameter int  NSLOT = 2,
  localparam int PW    = $clog2(NSLOT)
) (
  input  logic                   clk,
  input  logic                   i_wr_en,
  input  logic                   i_commit,
  input  logic [PW-1:0]          i_wr_slot,
  input  logic [IW-1:0]          i_beat_idx,
  input  logic [NROWS-1:0][7:0]  i_beat,
  input  logic [PW-1:0]          i_rd_slot,
  output logic [NB-1:0][7:0]     o_rd_block
);

  // Lanes at or below the closing beat keep their data; the rest are padded.
  logic [NBEATS-1:0] w_keep;
  assign w_keep = (NBEATS'(2) << i_beat_idx) - NBEATS'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NBEATS; gi++) begin : g_lane
      localparam logic [IW-1:0] LANE = IW'(gi);
      beat_t r_lane [NSLOT];

      always_ff @(posedge clk) begin
        if (i_wr_en && (i_beat_idx == LANE)) begin
          r_lane[i_wr_slot] <= i_beat;
        end else if (i_commit && !w_keep[gi]) begin
          r_lane[i_wr_slot] <= '0;
        end
      end

      assign o_rd_block[gi*NROWS +: NROWS] = r_lane[i_rd_slot];
    end
  endgenerate

endmodule

// File: rtl/aes_in_block_sched.sv
// Packs 32-bit beats into 16-byte blocks, buffers completed blocks and hands
// them to the AES core with a start pulse under valid/ready back-pressure.
module aes_in_block_sched
  import aes_ctrl_pkg::*;
#(
  parameter int  NSLOT = 2,
  localparam int PW    = $clog2(NSLOT),
  localparam int LW    = $clog2(NSLOT + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  s_valid,
  input  logic [NROWS-1:0][7:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  core_ready,
  output logic                  core_start,
  output logic [NB-1:0][7:0]    core_block,
  output logic [15:0]           blk_cnt,
  output logic                  short_blk,
  output logic [LW-1:0]         buf_level
);

  logic          r_run;
  logic [IW-1:0] r_beat_idx;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  iss_state_t    r_state;
  block_t        r_core_block;
  logic [15:0]   r_blk_cnt;
  logic          r_short;

  logic          w_accept;
  logic          w_commit;
  logic          w_issue;
  iss_state_t    w_next_state;
  block_t        w_rd_block;

  // Ready depends only on registered state, so core_ready never reaches s_ready.
  assign s_ready  = r_run && (r_level < LW'(NSLOT));
  assign w_accept = s_valid && s_ready;
  assign w_commit = w_accept && (s_last || (r_beat_idx == IW'(NBEATS - 1)));

  aes_blk_slots #(
    .NSLOT (NSLOT)
  ) u_slots (
    .clk        (clk),
    .i_wr_en    (w_accept),
    .i_commit   (w_commit),
    .i_wr_slot  (r_wr_ptr),
    .i_beat_idx (r_beat_idx),
    .i_beat     (s_data),
    .i_rd_slot  (r_rd_ptr),
    .o_rd_block (w_rd_block)
  );

  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    case (r_state)
      O_IDLE: begin
        if ((r_level != '0) && core_ready) begin
          w_issue      = 1'b1;
          w_next_state = O_ISSUE;
        end
      end
      O_ISSUE: w_next_state = O_GUARD;
      O_GUARD: w_next_state = O_IDLE;
      default: w_next_state = O_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_run        <= 1'b0;
      r_beat_idx   <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_state      <= O_IDLE;
      r_core_block <= '0;
      r_blk_cnt    <= '0;
      r_short      <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_state <= w_next_state;
      r_short <= w_commit && (r_beat_idx != IW'(NBEATS - 1));

      if (w_commit) begin
        r_beat_idx <= '0;
        r_wr_ptr   <= r_wr_ptr + PW'(1);
      end else if (w_accept) begin
        r_beat_idx <= r_beat_idx + IW'(1);
      end

      if (w_issue) begin
        r_core_block <= w_rd_block;
        r_rd_ptr     <= r_rd_ptr + PW'(1);
        r_blk_cnt    <= r_blk_cnt + 16'd1;
      end

      // A commit and an issue on the same edge cancel in the level count.
      if (w_commit && !w_issue) begin
        r_level <= r_level + LW'(1);
      end else if (w_issue && !w_commit) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

  assign core_start = (r_state == O_ISSUE);
  assign core_block = r_core_block;
  assign blk_cnt    = r_blk_cnt;
  assign short_blk  = r_short;
  assign buf_level  = r_level;

endmodule

// File: tb/tb_aes_in_block_sched.sv
// Randomised and directed stimulus against a queue-based model of the block
// scheduler; every cycle compares all DUT outputs with the model.
module tb_aes_in_block_sched;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             s_valid = 1'b0;
  logic [3:0][7:0]  s_data = '0;
  logic             s_last = 1'b0;
  logic             core_ready = 1'b0;
  logic             s_ready;
  logic             core_start;
  logic [15:0][7:0] core_block;
  logic [15:0]      blk_cnt;
  logic             short_blk;
  logic [1:0]       buf_level;

  always #5 clk = ~clk;

  aes_in_block_sched #(.NSLOT(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .core_ready (core_ready),
    .core_start (core_start),
    .core_block (core_block),
    .blk_cnt    (blk_cnt),
    .short_blk  (short_blk),
    .buf_level  (buf_level)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: completed blocks waiting for the core, the block being
  // assembled, issued-block counter and the cycle of the last issue.
  bit           m_run;
  logic [127:0] m_q[$];
  logic [127:0] m_part;
  int           m_idx;
  logic [15:0]  m_cnt;
  logic [127:0] m_hold;
  int           m_edge;
  int           m_last_issue;
  bit           m_acc;
  logic         g_cr;

  task automatic model_clear();
    m_run = 0;
    m_q.delete();
    m_part = '0;
    m_idx = 0;
    m_cnt = '0;
    m_hold = '0;
    m_last_issue = m_edge - 100;
    m_acc = 0;
  endtask

  // One clock cycle: drive inputs, predict the edge, check outputs after it.
  task automatic tick(input logic v, input logic [31:0] d, input logic l, input logic cr);
    bit issue;
    bit short_exp;
    bit rdy;
    s_valid = v;
    s_data = d;
    s_last = l;
    core_ready = cr;
    #1;
    rdy = m_run && (m_q.size() < 2);
    chk("s_ready", s_ready, rdy);
    m_acc = v && rdy;
    issue = (m_q.size() > 0) && cr && (m_edge - m_last_issue >= 3);
    short_exp = 0;
    if (issue) begin
      m_hold = m_q.pop_front();
      m_cnt = m_cnt + 16'd1;
      m_last_issue = m_edge;
    end
    if (m_acc) begin
      m_part[m_idx*32 +: 32] = d;
      if (m_idx == 3 || l) begin
        short_exp = (m_idx < 3);
        m_q.push_back(m_part);
        m_part = '0;
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
    m_run = 1;
    m_edge++;
    @(negedge clk);
    chk("core_start", core_start, issue);
    chk("core_block", core_block, m_hold);
    chk("blk_cnt", blk_cnt, m_cnt);
    chk("buf_level", buf_level, m_q.size());
    chk("short_blk", short_blk, short_exp);
    if (issue) $display("issue cnt=%h block=%h level=%0d", m_cnt, m_hold, m_q.size());
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    int n = 0;
    do begin
      tick(1'b1, d, l, g_cr);
      n++;
    end while (!m_acc && n < 200);
    if (!m_acc) chk("send_timeout", m_acc, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, $urandom, 1'b0, g_cr);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = '0;
    core_ready = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_block", core_block, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    chk("rst_short_blk", short_blk, 0);
    chk("rst_buf_level", buf_level, 0);
    model_clear();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        rl;
    logic        cr;
    bit          pend;
    int          cr_mode;

    m_edge = 0;
    model_clear();
    g_cr = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();

    // Single full block with the core ready.
    send_beat(32'h03020100, 1'b0);
    send_beat(32'h07060504, 1'b0);
    send_beat(32'h0B0A0908, 1'b0);
    send_beat(32'h0F0E0D0C, 1'b0);
    idle(4);
    chk("t1_block", core_block, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("t1_cnt", blk_cnt, 16'd1);

    // Back-pressure: two blocks fill the buffer, the ninth beat stalls.
    g_cr = 1'b0;
    for (int b = 0; b < 8; b++) send_beat($urandom, 1'b0);
    repeat (4) tick(1'b1, 32'hA5A5_0009, 1'b0, 1'b0);
    chk("t2_full", buf_level, 2);
    g_cr = 1'b1;
    send_beat(32'hA5A5_0009, 1'b0);
    for (int b = 0; b < 3; b++) send_beat($urandom, 1'b0);
    idle(15);
    chk("t2_cnt", blk_cnt, 16'd4);

    // Short block: two beats, the second closing it.
    send_beat(32'h13121110, 1'b0);
    send_beat(32'h17161514, 1'b1);
    idle(5);
    chk("t3_pad", core_block[15:8], 64'h0);
    chk("t3_cnt", blk_cnt, 16'd5);

    // Commit and issue on the same edge with one block buffered.
    g_cr = 1'b0;
    for (int b = 0; b < 7; b++) send_beat($urandom, 1'b0);
    g_cr = 1'b1;
    send_beat($urandom, 1'b0);
    chk("t4_level", buf_level, 1);
    idle(8);

    // Reset with one block buffered and a partial block in progress.
    g_cr = 1'b0;
    for (int b = 0; b < 6; b++) send_beat($urandom, 1'b0);
    do_reset();
    g_cr = 1'b1;
    send_beat(32'h23222120, 1'b0);
    send_beat(32'h27262524, 1'b0);
    send_beat(32'h2B2A2928, 1'b0);
    send_beat(32'h2F2E2D2C, 1'b0);
    idle(8);
    chk("t5_block", core_block, 128'h2F2E2D2C2B2A29282726252423222120);
    chk("t5_cnt", blk_cnt, 16'd1);

    // Counter wrap.
    force dut.r_blk_cnt = 16'hFFFF;
    #1;
    release dut.r_blk_cnt;
    m_cnt = 16'hFFFF;
    chk("t6_forced", blk_cnt, 16'hFFFF);
    for (int b = 0; b < 4; b++) send_beat($urandom, 1'b0);
    idle(6);
    chk("t6_wrap", blk_cnt, 16'h0000);

    // Random traffic with varying core availability and one mid-run reset.
    pend = 0;
    rd = '0;
    rl = 1'b0;
    cr_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 0) cr_mode = $urandom_range(2);
      if (c == 1500) begin
        do_reset();
        pend = 0;
      end
      if (!pend && ($urandom_range(3) != 0)) begin
        pend = 1;
        rd = $urandom;
        rl = ($urandom_range(4) == 0);
      end
      cr = (cr_mode == 0) ? 1'b1 :
           (cr_mode == 1) ? 1'($urandom_range(1)) : 1'($urandom_range(7) == 0);
      tick(pend, rd, rl, cr);
      if (m_acc) pend = 0;
    end
    g_cr = 1'b1;
    idle(12);
    chk("final_drain", buf_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
